ntt_io_sequencer: RTL and testbench



---
 rtl/ntt_io_sequencer_pkg.sv | 9 +
 rtl/ntt_io_sequencer_row_serdes.sv | 34 +++
 rtl/ntt_io_sequencer.sv | 123 ++++++++++++
 tb/tb_ntt_io_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_io_sequencer_pkg.sv
// ntt_io_sequencer_pkg: shared FSM states, counter widths and defaults for the NTT I/O sequencer
package ntt_io_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, WAIT, READ, CAPTURE, UNLOAD} state_t;
  localparam int DEF_NUM_MODULI = 40;
  localparam int ROW_W = 8;
  function automatic int lane_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ntt_io_sequencer_row_serdes.sv
// row_serdes: one row buffer with lane counter, serial write/read and parallel load/unload
module row_serdes import ntt_io_sequencer_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SIZE = 257,
  parameter int LW = lane_bits(SIZE)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    wr,
  input  logic                    step,
  input  logic                    load,
  input  logic [WIDTH-1:0]        word_in,
  input  logic [WIDTH*SIZE-1:0]   row_in,
  output logic [LW-1:0]           lane,
  output logic [WIDTH*SIZE-1:0]   row_out,
  output logic [WIDTH-1:0]        word_out
);
  logic [WIDTH-1:0] mem [SIZE];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= '0;
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    end else begin
      if (load) for (int i = 0; i < SIZE; i++) mem[i] <= row_in[i*WIDTH +: WIDTH];
      else if (wr) mem[lane] <= word_in;
      lane <= (clr || load) ? '0 : step ? (lane == LW'(SIZE-1) ? '0 : lane + 1'b1) : lane;
    end
  end
  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign row_out[g*WIDTH +: WIDTH] = mem[g];
  end
  assign word_out = mem[lane];
endmodule

// File: rtl/ntt_io_sequencer.sv
// ntt_io_sequencer: streams rows into the ntt core, runs it and streams the result back out.
// Define NTT_IO_PREFETCH_EN to add a second capture buffer that prefetches the next row during unload.
module ntt_io_sequencer import ntt_io_sequencer_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SIZE = 257,
  parameter int ROWS = 1,
  parameter int READ_LATENCY = 2,
  parameter int NUM_MODULI = DEF_NUM_MODULI
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_start,
  input  logic [5:0]            job_mod_idx,
  output logic                  busy,
  output logic                  job_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  start,
  output logic [5:0]            mod_idx,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [8*SIZE-1:0]     mem_addr,
  output logic [WIDTH*SIZE-1:0] din,
  input  logic [WIDTH*SIZE-1:0] dout,
  input  logic                  done
);
  localparam int LW = lane_bits(SIZE);
  state_t state, next;
  logic [ROW_W-1:0] row_cnt, addr_row;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [LW-1:0] lane;
  logic accept, in_fire, out_fire, last_lane, last_row, row_end, cap_now, have_row, pf_issue;
  assign accept = state == IDLE && job_start && int'(job_mod_idx) < NUM_MODULI;
  assign busy = state != IDLE;
  assign s_ready = state == LOAD;
  assign m_valid = state == UNLOAD;
  assign in_fire = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;
  assign last_lane = lane == LW'(SIZE-1);
  assign last_row = row_cnt == ROW_W'(ROWS-1);
  assign row_end = out_fire && last_lane;
  assign cap_now = rd_pipe[READ_LATENCY-1];
  assign start = state == RUN;
  assign mem_write = state == WRITE;
  assign mem_read = state == READ || pf_issue;
  assign addr_row = pf_issue ? row_cnt + 1'b1 : (state == READ || state == WRITE) ? row_cnt : '0;
  assign mem_addr = {SIZE{addr_row}};
`ifdef NTT_IO_PREFETCH_EN
  localparam int PF_LANE = SIZE-1-READ_LATENCY > 0 ? SIZE-1-READ_LATENCY : 0;
  localparam state_t MISS = CAPTURE;
  logic cur, pf_issued, pf_ready, swap;
  logic [LW-1:0] lanes [2];
  logic [WIDTH*SIZE-1:0] rows [2];
  logic [WIDTH-1:0] words [2];
  // cur is the buffer being loaded/unloaded; captures always land in the other one
  for (genvar g = 0; g < 2; g++) begin : g_buf
    row_serdes #(.WIDTH(WIDTH), .SIZE(SIZE), .LW(LW)) u_buf (
      .clk(clk), .reset(reset), .clr(accept),
      .wr(in_fire && cur == 1'(g)), .step((in_fire || out_fire) && cur == 1'(g)),
      .load(cap_now && cur != 1'(g)), .word_in(s_data), .row_in(dout),
      .lane(lanes[g]), .row_out(rows[g]), .word_out(words[g]));
  end
  assign lane = lanes[cur];
  assign din = rows[cur];
  assign m_data = words[cur];
  assign have_row = pf_ready || cap_now;
  assign pf_issue = state == UNLOAD && !pf_issued && !last_row && lane == LW'(PF_LANE);
  assign swap = (state == CAPTURE && have_row) || (row_end && !last_row && have_row);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= 1'b0;
      pf_issued <= 1'b0;
      pf_ready <= 1'b0;
    end else begin
      cur <= swap ? ~cur : cur;
      pf_issued <= swap ? 1'b0 : pf_issued || pf_issue;
      pf_ready <= swap ? 1'b0 : pf_ready || cap_now;
    end
  end
`else
  localparam state_t MISS = READ;
  row_serdes #(.WIDTH(WIDTH), .SIZE(SIZE), .LW(LW)) u_buf (
    .clk(clk), .reset(reset), .clr(accept), .wr(in_fire), .step(in_fire || out_fire),
    .load(cap_now), .word_in(s_data), .row_in(dout),
    .lane(lane), .row_out(din), .word_out(m_data));
  assign have_row = cap_now;
  assign pf_issue = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? LOAD : IDLE;
      LOAD:    next = (in_fire && last_lane) ? WRITE : LOAD;
      WRITE:   next = last_row ? RUN : LOAD;
      RUN:     next = WAIT;
      WAIT:    next = done ? READ : WAIT;
      READ:    next = CAPTURE;
      CAPTURE: next = have_row ? UNLOAD : CAPTURE;
      UNLOAD:  next = !row_end ? UNLOAD : last_row ? IDLE : have_row ? UNLOAD : MISS;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row_cnt <= '0;
      rd_pipe <= '0;
      mod_idx <= '0;
      job_err <= 1'b0;
    end else begin
      state <= next;
      rd_pipe <= READ_LATENCY'({rd_pipe, mem_read});
      job_err <= state == IDLE && job_start && !accept;
      if (accept) mod_idx <= job_mod_idx;
      if (accept || (state == WAIT && done)) row_cnt <= '0;
      else if ((state == WRITE || row_end) && !last_row) row_cnt <= row_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ntt_io_sequencer.sv
// tb_ntt_io_sequencer: scoreboard bench with a behavioural ntt core that adds 1 to every word
module tb_ntt_io_sequencer;
  localparam int WIDTH = 32, SIZE = 5, ROWS = 2, RL = 2, N = SIZE * ROWS;
`ifdef NTT_IO_PREFETCH_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = RL + 2;
`endif
  logic clk = 0, reset = 1, job_start = 0, s_valid = 0, m_ready = 1;
  logic [5:0] job_mod_idx = 0;
  logic [WIDTH-1:0] s_data = 0;
  logic busy, job_err, s_ready, m_valid, start, mem_read, mem_write, done;
  logic [WIDTH-1:0] m_data;
  logic [5:0] mod_idx;
  logic [8*SIZE-1:0] mem_addr;
  logic [WIDTH*SIZE-1:0] din, dout;

  ntt_io_sequencer #(.WIDTH(WIDTH), .SIZE(SIZE), .ROWS(ROWS), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .job_start(job_start), .job_mod_idx(job_mod_idx),
    .busy(busy), .job_err(job_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .start(start), .mod_idx(mod_idx),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .din(din),
    .dout(dout), .done(done));

  always #5 clk = ~clk;

  // behavioural core: row memory, +1 transform on start, done 10 cycles later, RL-stage read pipe
  logic [WIDTH*SIZE-1:0] cmem [256];
  logic [WIDTH*SIZE-1:0] rpipe [RL];
  int dcnt = 0;
  always @(posedge clk) begin
    if (mem_write) cmem[mem_addr[7:0]] <= din;
    if (start) begin
      for (int r = 0; r < 256; r++)
        for (int l = 0; l < SIZE; l++) cmem[r][l*WIDTH +: WIDTH] <= cmem[r][l*WIDTH +: WIDTH] + 1;
      dcnt <= 10;
    end else if (dcnt != 0) dcnt <= dcnt - 1;
    rpipe[0] <= mem_read ? cmem[mem_addr[7:0]] : {SIZE{32'hDEADBEEF}};
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign dout = rpipe[RL-1];
  assign done = dcnt == 1;

  int checks = 0, errors = 0, cyc = 0, m_mode = 0;
  int exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  int got_cyc[$];
  logic [8*SIZE-1:0] wa_q[$];
  logic [WIDTH*SIZE-1:0] wd_q[$];
  int start_cnt, err_cnt, busy_cnt, stall_viol, last_hs, busy_fall;
  logic [5:0] start_mod;
  logic prev_stall = 0, prev_busy = 0;
  logic [WIDTH-1:0] prev_data = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(posedge clk); #1;
    m_ready = (m_mode == 1) ? ~m_ready : 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) begin got_q.push_back(m_data); got_cyc.push_back(cyc); last_hs = cyc; end
    if (mem_write) begin wa_q.push_back(mem_addr); wd_q.push_back(din); end
    if (start) begin start_cnt++; start_mod = mod_idx; end
    if (job_err) err_cnt++;
    if (busy) busy_cnt++;
    if (prev_busy && !busy) busy_fall = cyc;
    if (prev_stall && m_valid && m_data !== prev_data) stall_viol++;
    prev_stall = m_valid && !m_ready;
    prev_data = m_data;
    prev_busy = busy;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_mon;
    exp_q.delete(); got_q.delete(); got_cyc.delete(); wa_q.delete(); wd_q.delete();
    start_cnt = 0; err_cnt = 0; busy_cnt = 0; stall_viol = 0; last_hs = -1; busy_fall = -1; start_mod = 0;
  endtask

  task automatic start_job(input logic [5:0] idx);
    job_start = 1; job_mod_idx = idx;
    tick;
    job_start = 0;
  endtask

  task automatic feed(input int base, input bit gap, input bit inject);
    int t;
    for (int i = 0; i < N; i++) begin
      if (gap && (i % 3 == 1)) begin s_valid = 0; tick; tick; end
      s_valid = 1; s_data = WIDTH'(base + i);
      exp_q.push_back(base + i + 1);
      if (inject && i == 2) begin job_start = 1; job_mod_idx = 12; end
      if (inject && i == 3) begin job_start = 1; job_mod_idx = 40; end
      t = 0;
      while (!s_ready && t < 100) begin tick; t++; end
      checks++;
      if (t >= 100) begin errors++; $display("FAIL feed_timeout word %0d: s_ready=0 for %0d cycles, required 1", i, t); end
      tick;
      job_start = 0;
    end
    s_valid = 0;
  endtask

  task automatic finish_job(input logic [5:0] idx, input int base, input bit gap_chk);
    int t;
    logic [WIDTH-1:0] g;
    int e;
    logic [WIDTH*SIZE-1:0] ed;
    t = 0;
    while (busy && t < 2000) begin tick; t++; end
    tick; tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL job_timeout: busy=%0b, required 0", busy); end
    checks++;
    if (got_q.size() !== N) begin errors++; $display("FAIL out_count: got %0d words, required %0d", got_q.size(), N); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== WIDTH'(e)) begin errors++; $display("FAIL out_word: got %0d, required %0d", g, e); end
    end
    checks++;
    if (wa_q.size() !== ROWS) begin errors++; $display("FAIL write_count: got %0d, required %0d", wa_q.size(), ROWS); end
    for (int r = 0; r < wa_q.size(); r++) begin
      for (int l = 0; l < SIZE; l++) ed[l*WIDTH +: WIDTH] = WIDTH'(base + r * SIZE + l);
      checks++;
      if (wa_q[r] !== {SIZE{8'(r)}}) begin errors++; $display("FAIL write_addr row %0d: got %h, required %h", r, wa_q[r], {SIZE{8'(r)}}); end
      checks++;
      if (wd_q[r] !== ed) begin errors++; $display("FAIL write_din row %0d: got %h, required %h", r, wd_q[r], ed); end
    end
    checks++;
    if (start_cnt !== 1) begin errors++; $display("FAIL start_count: got %0d, required 1", start_cnt); end
    checks++;
    if (start_mod !== idx) begin errors++; $display("FAIL start_mod_idx: got %0d, required %0d", start_mod, idx); end
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL spurious_job_err: got %0d pulses, required 0", err_cnt); end
    checks++;
    if (busy_fall !== last_hs + 1) begin errors++; $display("FAIL busy_fall: fell at %0d, required %0d", busy_fall, last_hs + 1); end
    if (gap_chk && got_cyc.size() == N) begin
      checks++;
      if (got_cyc[SIZE] - got_cyc[SIZE-1] !== EXP_GAP)
        begin errors++; $display("FAIL row_gap: got %0d cycles, required %0d", got_cyc[SIZE] - got_cyc[SIZE-1], EXP_GAP); end
    end
  endtask

  task automatic test_reset;
    reset = 1;
    tick; tick;
    checks++;
    if ({busy, job_err, s_ready, m_valid, start, mem_read, mem_write} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b, required 0", {busy, job_err, s_ready, m_valid, start, mem_read, mem_write}); end
    checks++;
    if (mod_idx !== 6'd0) begin errors++; $display("FAIL reset_mod_idx: got %0d, required 0", mod_idx); end
    checks++;
    if (m_data !== '0 || din !== '0) begin errors++; $display("FAIL reset_data: m_data=%h din=%h, required 0", m_data, din); end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h, required 0", mem_addr); end
    reset = 0;
    tick;
  endtask

  task automatic test_basic;
    clear_mon; m_mode = 0;
    start_job(3);
    feed(1, 0, 0);
    finish_job(3, 1, 1);
  endtask

  task automatic test_bad_index;
    clear_mon;
    start_job(40);
    repeat (6) tick;
    checks++;
    if (err_cnt !== 1) begin errors++; $display("FAIL bad_idx_err: got %0d pulses, required 1", err_cnt); end
    checks++;
    if (busy_cnt !== 0) begin errors++; $display("FAIL bad_idx_busy: busy high %0d cycles, required 0", busy_cnt); end
    checks++;
    if (start_cnt !== 0) begin errors++; $display("FAIL bad_idx_start: got %0d starts, required 0", start_cnt); end
  endtask

  task automatic test_backpressure;
    clear_mon; m_mode = 1;
    start_job(7);
    feed(50, 1, 0);
    finish_job(7, 50, 0);
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: %0d changes during stall, required 0", stall_viol); end
    m_mode = 0;
    tick;
  endtask

  task automatic test_ignored_start;
    clear_mon; m_mode = 0;
    start_job(21);
    feed(300, 0, 1);
    finish_job(21, 300, 1);
  endtask

  task automatic test_reset_mid;
    int t;
    clear_mon; m_mode = 0;
    start_job(9);
    feed(400, 0, 0);
    t = 0;
    while (start_cnt == 0 && t < 100) begin tick; t++; end
    tick; tick;
    checks++;
    if (busy !== 1'b1 || mod_idx !== 6'd9) begin errors++; $display("FAIL pre_reset: busy=%0b mod_idx=%0d, required 1 and 9", busy, mod_idx); end
    #2 reset = 1;
    #1;
    checks++;
    if ({busy, job_err, s_ready, m_valid, start, mem_read, mem_write} !== 7'b0)
      begin errors++; $display("FAIL mid_reset_ctrl: got %b, required 0", {busy, job_err, s_ready, m_valid, start, mem_read, mem_write}); end
    checks++;
    if (mod_idx !== 6'd0 || m_data !== '0 || din !== '0 || mem_addr !== '0)
      begin errors++; $display("FAIL mid_reset_data: mod_idx=%0d m_data=%h din=%h addr=%h, required 0", mod_idx, m_data, din, mem_addr); end
    tick;
    reset = 0;
    tick;
    clear_mon;
    start_job(5);
    feed(500, 0, 0);
    finish_job(5, 500, 1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_index;
    test_backpressure;
    test_ignored_start;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
